// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and parameter helpers for the PE array sequencer.
// FSM state encoding plus the derived-size functions used by the top and its timer.
package pe_array_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_EMIT = 2'd3
   } state_e;

   function automatic int calc_ndiag(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

   function automatic int calc_lat(input int delay_cycles, input int cols, input int extra_lat);
      return delay_cycles * cols + extra_lat;
   endfunction

   function automatic int calc_cnt_w(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/pe_lat_timer.sv
// Countdown timer covering the array pipeline latency; expires LAT edges after load.
// expire_o is only meaningful after a load; it idles high once the count reaches zero.
module pe_lat_timer
   import pe_array_ctrl_pkg::*;
#(
   parameter int LAT = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic expire_o
);

   localparam int CNT_W = calc_cnt_w(LAT);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Pass sequencer for the systolic PE array: load ifmap, wait array latency, emit psums.
// Input taken only in LOAD; result held in EMIT until out_ready, unbounded backpressure.
module pe_array_seq_ctrl
   import pe_array_ctrl_pkg::*;
#(
   parameter int PE_WIDTH     = 4,
   parameter int NUM_ROWS     = 3,
   parameter int NUM_COLS     = 3,
   parameter int DELAY_CYCLES = 10,
   parameter int EXTRA_LAT    = 0,
   parameter int PASS_W       = 8,
   localparam int NDIAG       = calc_ndiag(NUM_ROWS, NUM_COLS),
   localparam int LAT         = calc_lat(DELAY_CYCLES, NUM_COLS, EXTRA_LAT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [PASS_W-1:0]            num_passes,
   output logic                         busy,
   output logic                         done,
   output logic [PASS_W-1:0]            pass_idx,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PE_WIDTH*NDIAG-1:0]    in_data,
   output logic [PE_WIDTH*NDIAG-1:0]    arr_ifmap_flat,
   input  logic [PE_WIDTH*NUM_COLS-1:0] arr_psum_flat,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PE_WIDTH*NUM_COLS-1:0] out_data
);

   state_e                         state_q;
   logic [PASS_W-1:0]              pass_idx_q;
   logic [PASS_W-1:0]              npass_q;
   logic [PE_WIDTH*NDIAG-1:0]      ifmap_q;
   logic [PE_WIDTH*NUM_COLS-1:0]   out_data_q;
   logic                           out_valid_q;
   logic                           done_q;
   logic                           tmr_load;
   logic                           tmr_expire;

   assign in_ready = (state_q == ST_LOAD);
   assign tmr_load = in_valid && in_ready;

   pe_lat_timer #(
      .LAT (LAT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (tmr_load),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pass_idx_q  <= '0;
         npass_q     <= '0;
         ifmap_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  // A zero-pass job completes on the spot without touching either stream.
                  if (num_passes != '0) begin
                     npass_q    <= num_passes;
                     pass_idx_q <= '0;
                     state_q    <= ST_LOAD;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (in_valid) begin
                  ifmap_q <= in_data;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (tmr_expire) begin
                  out_data_q  <= arr_psum_flat;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (pass_idx_q == npass_q - 1'b1) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     pass_idx_q <= pass_idx_q + 1'b1;
                     state_q    <= ST_LOAD;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;
   assign pass_idx       = pass_idx_q;
   assign arr_ifmap_flat = ifmap_q;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Bench for pe_array_seq_ctrl: timeline reference model with a result scoreboard.
module tb_pe_array_seq_ctrl;

   localparam int PW     = 4;
   localparam int NR     = 3;
   localparam int NC     = 3;
   localparam int DC     = 10;
   localparam int PASS_W = 8;
   localparam int NDIAG  = NR + NC - 1;
   localparam int LAT    = DC * NC;
   localparam int DW     = PW * NDIAG;
   localparam int OW     = PW * NC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start = 1'b0;
   logic [PASS_W-1:0] num_passes = '0;
   logic              busy, done, in_ready, out_valid;
   logic [PASS_W-1:0] pass_idx;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [DW-1:0]     in_data = '0;
   logic [DW-1:0]     arr_ifmap_flat;
   logic [OW-1:0]     arr_psum_flat = '0;
   logic [OW-1:0]     out_data;

   pe_array_seq_ctrl #(
      .PE_WIDTH(PW), .NUM_ROWS(NR), .NUM_COLS(NC), .DELAY_CYCLES(DC), .EXTRA_LAT(0), .PASS_W(PASS_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .busy(busy), .done(done),
      .pass_idx(pass_idx), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .arr_ifmap_flat(arr_ifmap_flat), .arr_psum_flat(arr_psum_flat), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   // Second instance configured for a one-cycle latency (no per-PE delay, one extra cycle).
   logic              start1 = 1'b0;
   logic [PASS_W-1:0] np1 = '0;
   logic              busy1, done1, in_ready1, out_valid1;
   logic [PASS_W-1:0] pass_idx1;
   logic              in_valid1 = 1'b0;
   logic              out_ready1 = 1'b0;
   logic [DW-1:0]     in_data1 = '0;
   logic [DW-1:0]     ifmap1;
   logic [OW-1:0]     out_data1;

   pe_array_seq_ctrl #(
      .PE_WIDTH(PW), .NUM_ROWS(NR), .NUM_COLS(NC), .DELAY_CYCLES(0), .EXTRA_LAT(1), .PASS_W(PASS_W)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start1), .num_passes(np1), .busy(busy1), .done(done1),
      .pass_idx(pass_idx1), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .arr_ifmap_flat(ifmap1), .arr_psum_flat(arr_psum_flat), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_data(out_data1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Array model: psum output is a pseudo-random function of the edge index.
   function automatic logic [OW-1:0] psum_f(input int e);
      logic [31:0] h;
      h = e * 32'h9E37_79B1;
      return h[27:16] ^ h[11:0];
   endfunction

   // Reference model: per-job timeline in edge indices.
   int            n = 0;
   bit            m_busy = 0;
   bit            m_inflight = 0;
   int            m_np = 0;
   int            m_pass = 0;
   int            m_due = 0;
   int            done_due = -10;
   int            start_edge = 0;
   int            done_edge = 0;
   logic [DW-1:0] m_ifmap = '0;
   logic [OW-1:0] sbq[$];
   int            hs_edges[$];

   // Negedge n precedes active edge n; checks use the model state, then edge-n events update it.
   initial begin
      forever begin
         bit exp_ov;
         @(negedge clk);
         n++;
         if (rst) begin
            m_busy = 0; m_inflight = 0; m_pass = 0; m_ifmap = '0; done_due = -10;
            sbq.delete();
            chk("rst_out_data", 32'(out_data), 32'h0);
         end
         exp_ov = m_inflight && (n >= m_due);
         chk("busy", 32'(busy), 32'(m_busy));
         chk("in_ready", 32'(in_ready), 32'(m_busy && !m_inflight));
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         chk("done", 32'(done), 32'(n == done_due));
         chk("pass_idx", 32'(pass_idx), 32'(m_pass));
         chk("ifmap", 32'(arr_ifmap_flat), 32'(m_ifmap));
         if (exp_ov) begin
            if (sbq.size() == 0) chk("sb_empty", 32'(sbq.size()), 32'd1);
            else                 chk("out_data", 32'(out_data), 32'(sbq[0]));
         end
         arr_psum_flat = psum_f(n);
         if (!rst) begin
            if (start && !m_busy) begin
               if (num_passes != 0) begin
                  m_busy = 1; m_np = int'(num_passes); m_pass = 0; start_edge = n;
               end else begin
                  done_due = n + 1;
               end
            end else if (m_busy && !m_inflight && in_valid) begin
               m_inflight = 1;
               m_due = n + LAT + 1;
               m_ifmap = in_data;
               sbq.push_back(psum_f(n + LAT));
               hs_edges.push_back(n);
            end else if (exp_ov && out_ready) begin
               void'(sbq.pop_front());
               m_inflight = 0;
               if (m_pass == m_np - 1) begin
                  m_busy = 0; done_due = n + 1; done_edge = n;
               end else begin
                  m_pass++;
               end
            end
         end
      end
   end

   // Stream driver: 0 = low, 1 = high, 2 = random per cycle.
   int            vmode = 0;
   int            rmode = 0;
   bit            drand = 1;
   logic [DW-1:0] dfix = '0;

   function automatic logic pick(input int m);
      if (m == 2) return logic'($urandom_range(0, 1));
      return (m == 1);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         in_valid  = pick(vmode);
         out_ready = pick(rmode);
         in_data   = drand ? DW'($urandom) : dfix;
      end
   end

   task automatic do_start(input int np);
      @(posedge clk);
      #1;
      start = 1'b1;
      num_passes = PASS_W'(np);
      @(posedge clk);
      #1;
      start = 1'b0;
      num_passes = PASS_W'($urandom);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (m_busy && k < budget) begin
         @(posedge clk);
         k++;
      end
      checks++;
      if (m_busy) begin
         errors++;
         $display("FAIL %s: job still running after %0d cycles, expected idle", name, budget);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_emit(input int budget, input string name);
      int k = 0;
      while (!(m_inflight && n >= m_due) && k < budget) begin
         @(posedge clk);
         k++;
      end
      checks++;
      if (k >= budget) begin
         errors++;
         $display("FAIL %s: no result after %0d cycles, expected EMIT", name, budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [OW-1:0] cap;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_ifmap", 32'(arr_ifmap_flat), 32'h0);
      rst = 1'b0;

      // Single pass with fixed data presented immediately.
      drand = 0; dfix = 20'h12345; vmode = 1; rmode = 1;
      do_start(1);
      wait_idle(200, "single");
      chk("single_ifmap", 32'(arr_ifmap_flat), 32'h12345);

      // Back-to-back four passes.
      drand = 1;
      hs_edges.delete();
      do_start(4);
      wait_idle(400, "b2b");
      chk("b2b_passes", 32'(hs_edges.size()), 32'd4);
      for (int i = 1; i < hs_edges.size(); i++)
         chk("b2b_period", 32'(hs_edges[i] - hs_edges[i-1]), 32'd32);
      chk("b2b_done_cycles", 32'(done_edge - start_edge), 32'd128);

      // Downstream backpressure for 50 cycles.
      rmode = 0;
      do_start(1);
      wait_emit(100, "bp");
      repeat (50) @(posedge clk);
      #1;
      chk("bp_valid_held", 32'(out_valid), 32'h1);
      chk("bp_data_held", 32'(out_data), 32'(psum_f(hs_edges[$] + LAT)));
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      rmode = 1;
      wait_idle(50, "bp");

      // Upstream stall, then spurious valids while waiting.
      vmode = 0;
      do_start(2);
      repeat (20) @(posedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'h1);
      vmode = 1;
      while (!m_inflight) @(posedge clk);
      vmode = 2;
      wait_idle(300, "stall");

      // Zero-pass job.
      vmode = 1;
      do_start(0);
      chk("zero_done", 32'(done), 32'h1);
      chk("zero_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      chk("zero_done_clear", 32'(done), 32'h0);

      // Start while busy is ignored.
      hs_edges.delete();
      do_start(2);
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1; num_passes = 8'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(300, "start_busy");
      chk("start_busy_passes", 32'(hs_edges.size()), 32'd2);

      // Randomized jobs.
      repeat (6) begin
         vmode = 2; rmode = 2;
         do_start($urandom_range(1, 3));
         wait_idle(1000, "random");
      end

      // Full pass-count range.
      vmode = 1; rmode = 1;
      hs_edges.delete();
      do_start(255);
      wait_idle(9000, "full_range");
      chk("full_range_passes", 32'(hs_edges.size()), 32'd255);

      // Reset while pass 2 of 5 sits in EMIT.
      do_start(5);
      while (m_pass != 2 && m_busy) @(posedge clk);
      rmode = 0;
      wait_emit(100, "rst_emit");
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      chk("arst_pass_idx", 32'(pass_idx), 32'h0);
      chk("arst_out_data", 32'(out_data), 32'h0);
      chk("arst_ifmap", 32'(arr_ifmap_flat), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rmode = 1;
      do_start(1);
      wait_idle(200, "post_reset");

      // One-cycle latency instance: capture on the edge after the handshake.
      @(posedge clk);
      #1;
      start1 = 1'b1; np1 = 8'd1; in_valid1 = 1'b1; in_data1 = 20'hABCDE; out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      chk("lat1_in_ready", 32'(in_ready1), 32'h1);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      chk("lat1_wait_valid", 32'(out_valid1), 32'h0);
      chk("lat1_ifmap", 32'(ifmap1), 32'hABCDE);
      @(posedge clk);
      cap = arr_psum_flat;
      #1;
      chk("lat1_out_valid", 32'(out_valid1), 32'h1);
      chk("lat1_out_data", 32'(out_data1), 32'(cap));
      @(posedge clk);
      #1;
      chk("lat1_done", 32'(done1), 32'h1);
      chk("lat1_busy", 32'(busy1), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_array_seq_ctrl.md
Name: pe_array_seq_ctrl

Overview:
- Sequencer for the systolic PE array (diagonal ifmap inputs, per-row psum outputs).
- Per pass:
  - accepts one ifmap vector from an upstream valid/ready stream;
  - drives it onto the array's flat ifmap input;
  - waits the array's fixed pipeline latency;
  - captures the psum outputs;
  - presents them downstream through valid/ready.
- Repeats for a programmed number of passes.
- Sits between the buffer/DMA front end and the PE array instance.

Parameters:
- PE_WIDTH, 4: data word width, matching the array.
- NUM_ROWS, 3: array rows.
- NUM_COLS, 3: array columns.
- DELAY_CYCLES, 10: per-PE latency, matching the array.
- EXTRA_LAT, 0: additional wait cycles for registered array I/O. Must be >= 0.
- PASS_W, 8: width of the pass count.
- Derived: NDIAG = NUM_ROWS+NUM_COLS-1; LAT = DELAY_CYCLES*NUM_COLS+EXTRA_LAT (must be >= 1); CNT_W = $clog2(LAT+1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- num_passes  in  PASS_W  pass count, latched on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the job completes.
- pass_idx  out  PASS_W  index of the current pass, 0-based.
- in_valid  in  1  upstream ifmap vector valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  PE_WIDTH*NDIAG  ifmap vector, same packing as the array flat input.
- arr_ifmap_flat  out  PE_WIDTH*NDIAG  registered drive to the array ifmap input.
- arr_psum_flat  in  PE_WIDTH*NUM_COLS  array psum outputs.
- out_valid  out  1  psum result valid.
- out_ready  in  1  downstream accept.
- out_data  out  PE_WIDTH*NUM_COLS  registered captured psums.

Behaviour:
- States: IDLE, LOAD, WAIT, EMIT. Encoding in the package.
- Reset (async, any state): state=IDLE.
  - busy=0, done=0, pass_idx=0.
  - in_ready=0, out_valid=0.
  - arr_ifmap_flat=0, out_data=0.
  - Latency counter=0, latched pass count=0.
- IDLE:
  - start=1 with num_passes>0: latch num_passes, pass_idx<=0, go to LOAD.
  - start=1 with num_passes==0: stay in IDLE, done=1 for the next cycle only. No handshakes.
- LOAD:
  - in_ready=1 (combinational from state).
  - On in_valid&in_ready: arr_ifmap_flat<=in_data, counter<=LAT-1, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where counter==0: out_data<=arr_psum_flat, out_valid<=1, go to EMIT.
  - The input handshake at edge k gives capture at edge k+LAT, with out_valid high from cycle k+LAT.
  - When LAT==1, WAIT lasts exactly one cycle.
- EMIT:
  - out_valid=1. out_data is held stable until accepted; backpressure can be unbounded.
  - On out_valid&out_ready:
    - if pass_idx==latched-1: go to IDLE, out_valid<=0, done pulses for 1 cycle (registered, coincident with busy falling);
    - else: pass_idx<=pass_idx+1, out_valid<=0, go to LOAD.
- arr_ifmap_flat holds its last value between passes and after the job; it changes only on an input handshake.
- start is ignored while busy. num_passes changes after latching have no effect.
- in_valid outside LOAD is ignored and no data is consumed. out_ready outside EMIT is ignored.
- Minimum pass period = 1 (LOAD) + LAT (WAIT) + 1 (EMIT) cycles, achieved with in_valid and out_ready held at 1.
- pass_idx covers the full PASS_W range; num_passes=2^PASS_W-1 completes without wrap.
- Reset asserted mid-WAIT or mid-EMIT: the pending result is discarded and no done pulse is produced. Post-reset, the block behaves as from cold.

Decomposition:
- Package pe_array_ctrl_pkg holds:
  - state enum typedef (IDLE/LOAD/WAIT/EMIT);
  - functions for NDIAG and LAT from the parameters;
  - CNT_W helper.
- One sub-module, pe_lat_timer:
  - parameter LAT;
  - load input and expire output;
  - async reset;
  - instantiated once for the WAIT countdown.
- The FSM, pass counter and data registers stay in the top.

Test Plan:
- Single pass, defaults (LAT=30): start with num_passes=1; in_data=0x12345 presented immediately.
  - arr_ifmap_flat=0x12345 one cycle after the handshake.
  - out_valid rises exactly 30 cycles after the handshake edge, with out_data = arr_psum_flat sampled at that edge (e.g. 0xABC from the array model).
  - done pulses once on acceptance.
- Back-to-back: num_passes=4, in_valid and out_ready tied 1.
  - 4 results with pass_idx 0..3, pass period 32 cycles.
  - done exactly once, 128 cycles after start acceptance ±1.
- Backpressure: out_ready=0 for 50 cycles in EMIT.
  - out_valid and out_data held stable, in_ready=0, no new load.
  - Releasing out_ready completes the pass normally.
- Upstream stall plus spurious input: in_valid=0 for 20 cycles in LOAD; in_valid=1 pulsed during WAIT.
  - No WAIT entry until the LOAD handshake.
  - The WAIT-time valid is not consumed and arr_ifmap_flat is unchanged.
- Edge cases:
  - num_passes=0: done pulses 1 cycle after start, busy stays 0.
  - start while busy: ignored.
  - EXTRA_LAT chosen so LAT=1: capture on the edge after the handshake.
- Reset mid-EMIT at pass 2 of 5:
  - All outputs zero immediately (async), no done.
  - A new start with num_passes=1 runs cleanly.
